// File: rtl/rps_match_controller.sv
// Match-level sequencer for stone-paper-scissors: hands move pairs to the round
// evaluator, tallies scores and declares a match winner. Optional history: RPS_ROUND_HISTORY_EN.
module rps_match_controller #(
  parameter int WIN_TARGET   = 2,
  parameter int MAX_ROUNDS   = 9,
  parameter int SCORE_W      = 4,
  parameter int EVAL_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               match_start,
  input  logic               abort,
  input  logic               moves_valid,
  input  logic [1:0]         p1_move,
  input  logic [1:0]         p2_move,
  output logic               moves_ready,
  output logic               eval_req,
  output logic [1:0]         eval_p1,
  output logic [1:0]         eval_p2,
  input  logic               eval_done,
  input  logic [1:0]         eval_winner,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [7:0]         round_cnt,
  output logic [2:0]         state,
  output logic               match_done,
  output logic [1:0]         match_winner,
  output logic               invalid_seen
`ifdef RPS_ROUND_HISTORY_EN
  ,
  output logic [15:0]        round_history
`endif
);

  localparam int TMO_W = $clog2(EVAL_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(EVAL_TIMEOUT - 1);
  localparam logic [SCORE_W-1:0] TARGET   = SCORE_W'(WIN_TARGET);
  localparam logic [7:0]         RND_LIM  = 8'(MAX_ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_ARM    = 3'b001,
    S_EVAL   = 3'b010,
    S_UPDATE = 3'b011,
    S_DONE   = 3'b100
  } state_t;

  state_t cur_st, nxt_st;

  logic [SCORE_W-1:0] p1_nxt, p2_nxt;
  logic [7:0]         rnd_nxt;
  logic               inv_nxt;
  logic [1:0]         win_nxt, ep1_nxt, ep2_nxt;
  logic [1:0]         cap_win, cap_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
`ifdef RPS_ROUND_HISTORY_EN
  logic [15:0]        hist_nxt;
`endif

  // Points decision once the round limit ends the match
  function automatic logic [1:0] points_winner(input logic [SCORE_W-1:0] a,
                                               input logic [SCORE_W-1:0] b);
    if (a > b)      return 2'b01;
    else if (b > a) return 2'b10;
    else            return 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) cur_st <= S_IDLE;
    else       cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st  = cur_st;
    p1_nxt  = p1_score;
    p2_nxt  = p2_score;
    rnd_nxt = round_cnt;
    inv_nxt = invalid_seen;
    win_nxt = match_winner;
    ep1_nxt = eval_p1;
    ep2_nxt = eval_p2;
    cap_nxt = cap_win;
    tmo_nxt = tmo_cnt;
`ifdef RPS_ROUND_HISTORY_EN
    hist_nxt = round_history;
`endif
    if (abort) begin
      nxt_st = S_IDLE;
    end else begin
      case (cur_st)
        S_IDLE, S_DONE: begin
          if (match_start) begin
            nxt_st  = S_ARM;
            p1_nxt  = '0;
            p2_nxt  = '0;
            rnd_nxt = '0;
            inv_nxt = 1'b0;
            win_nxt = 2'b00;
`ifdef RPS_ROUND_HISTORY_EN
            hist_nxt = '0;
`endif
          end
        end
        S_ARM: begin
          if (moves_valid) begin
            ep1_nxt = p1_move;
            ep2_nxt = p2_move;
            tmo_nxt = '0;
            nxt_st  = S_EVAL;
          end
        end
        S_EVAL: begin
          if (eval_done) begin
            cap_nxt = eval_winner;
            nxt_st  = S_UPDATE;
          end else if (tmo_cnt == TMO_LAST) begin
            win_nxt = 2'b11;
            nxt_st  = S_DONE;
          end else begin
            tmo_nxt = tmo_cnt + 1'b1;
          end
        end
        S_UPDATE: begin
          case (cap_win)
            2'b01: begin
              p1_nxt  = p1_score + 1'b1;
              rnd_nxt = round_cnt + 8'd1;
            end
            2'b10: begin
              p2_nxt  = p2_score + 1'b1;
              rnd_nxt = round_cnt + 8'd1;
            end
            2'b11:   inv_nxt = 1'b1;
            default: ;
          endcase
`ifdef RPS_ROUND_HISTORY_EN
          hist_nxt = {round_history[13:0], cap_win};
`endif
          // Match end is judged on the freshly updated tallies
          if (p1_nxt == TARGET) begin
            win_nxt = 2'b01;
            nxt_st  = S_DONE;
          end else if (p2_nxt == TARGET) begin
            win_nxt = 2'b10;
            nxt_st  = S_DONE;
          end else if (rnd_nxt == RND_LIM) begin
            win_nxt = points_winner(p1_nxt, p2_nxt);
            nxt_st  = S_DONE;
          end else begin
            nxt_st  = S_ARM;
          end
        end
        default: nxt_st = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_score     <= '0;
      p2_score     <= '0;
      round_cnt    <= '0;
      invalid_seen <= 1'b0;
      match_winner <= 2'b00;
      eval_p1      <= 2'b00;
      eval_p2      <= 2'b00;
      cap_win      <= 2'b00;
      tmo_cnt      <= '0;
`ifdef RPS_ROUND_HISTORY_EN
      round_history <= '0;
`endif
    end else begin
      p1_score     <= p1_nxt;
      p2_score     <= p2_nxt;
      round_cnt    <= rnd_nxt;
      invalid_seen <= inv_nxt;
      match_winner <= win_nxt;
      eval_p1      <= ep1_nxt;
      eval_p2      <= ep2_nxt;
      cap_win      <= cap_nxt;
      tmo_cnt      <= tmo_nxt;
`ifdef RPS_ROUND_HISTORY_EN
      round_history <= hist_nxt;
`endif
    end
  end

  assign state       = cur_st;
  assign moves_ready = (cur_st == S_ARM);
  assign eval_req    = (cur_st == S_EVAL);
  assign match_done  = (cur_st == S_DONE);

endmodule

// File: tb/tb_rps_match_controller.sv
// Directed bench for rps_match_controller: default instance plus a second
// instance limited to two decisive rounds, both driven by the same stimulus.
module tb_rps_match_controller;
  logic clk = 1'b0;
  logic reset, match_start, abort, moves_valid, eval_done;
  logic [1:0] p1_move, p2_move, eval_winner;

  logic       moves_ready, eval_req, match_done, invalid_seen;
  logic [1:0] eval_p1, eval_p2, match_winner;
  logic [3:0] p1_score, p2_score;
  logic [7:0] round_cnt;
  logic [2:0] state;

  logic       b_moves_ready, b_eval_req, b_match_done, b_invalid_seen;
  logic [1:0] b_eval_p1, b_eval_p2, b_match_winner;
  logic [3:0] b_p1_score, b_p2_score;
  logic [7:0] b_round_cnt;
  logic [2:0] b_state;
`ifdef RPS_ROUND_HISTORY_EN
  logic [15:0] round_history, b_round_history;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int req_cycles;

  always #5 clk = ~clk;

  rps_match_controller dut (
    .clk(clk), .reset(reset), .match_start(match_start), .abort(abort),
    .moves_valid(moves_valid), .p1_move(p1_move), .p2_move(p2_move),
    .moves_ready(moves_ready), .eval_req(eval_req), .eval_p1(eval_p1), .eval_p2(eval_p2),
    .eval_done(eval_done), .eval_winner(eval_winner),
    .p1_score(p1_score), .p2_score(p2_score), .round_cnt(round_cnt), .state(state),
    .match_done(match_done), .match_winner(match_winner), .invalid_seen(invalid_seen)
`ifdef RPS_ROUND_HISTORY_EN
    , .round_history(round_history)
`endif
  );

  rps_match_controller #(.MAX_ROUNDS(2)) dut_lim (
    .clk(clk), .reset(reset), .match_start(match_start), .abort(abort),
    .moves_valid(moves_valid), .p1_move(p1_move), .p2_move(p2_move),
    .moves_ready(b_moves_ready), .eval_req(b_eval_req), .eval_p1(b_eval_p1), .eval_p2(b_eval_p2),
    .eval_done(eval_done), .eval_winner(eval_winner),
    .p1_score(b_p1_score), .p2_score(b_p2_score), .round_cnt(b_round_cnt), .state(b_state),
    .match_done(b_match_done), .match_winner(b_match_winner), .invalid_seen(b_invalid_seen)
`ifdef RPS_ROUND_HISTORY_EN
    , .round_history(b_round_history)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_match();
    match_start = 1'b1;
    tick();
    match_start = 1'b0;
  endtask

  // Handshake one move pair, answer on the first EVAL cycle, stop at M+2
  task automatic play(input logic [1:0] m1, input logic [1:0] m2, input logic [1:0] w);
    p1_move = m1; p2_move = m2; moves_valid = 1'b1;
    tick();
    moves_valid = 1'b0;
    check("eval_req_on", eval_req, 1);
    check("eval_p1", eval_p1, m1);
    check("eval_p2", eval_p2, m2);
    eval_done = 1'b1; eval_winner = w;
    tick();
    eval_done = 1'b0; eval_winner = 2'b00;
    check("upd_state", state, 3'b011);
    check("upd_req_off", eval_req, 0);
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; match_start = 1'b0; abort = 1'b0; moves_valid = 1'b0;
    eval_done = 1'b0; p1_move = 2'b00; p2_move = 2'b00; eval_winner = 2'b00;
    tick(); tick();
    reset = 1'b0;
    check("rst_state", state, 0);
    check("rst_ready", moves_ready, 0);
    check("rst_req", eval_req, 0);
    check("rst_scores", {p1_score, p2_score}, 0);
    check("rst_round", round_cnt, 0);
    check("rst_done", match_done, 0);
    check("rst_winner", match_winner, 0);
    check("rst_inv", invalid_seen, 0);
    check("rst_evalp", {eval_p1, eval_p2}, 0);

    // P1 wins two straight rounds
    start_match();
    check("start_state", state, 3'b001);
    check("start_ready", moves_ready, 1);
    check("start_winner", match_winner, 0);
    play(2'b01, 2'b00, 2'b01);
    check("r1_p1", p1_score, 1);
    check("r1_round", round_cnt, 1);
    check("r1_ready", moves_ready, 1);
    play(2'b10, 2'b01, 2'b01);
    check("r2_p1", p1_score, 2);
    check("r2_round", round_cnt, 2);
    check("r2_done", match_done, 1);
    check("r2_winner", match_winner, 2'b01);
    check("r2_state", state, 3'b100);

    // Tie, invalid, then two P2 wins; restart from DONE clears the tallies
    start_match();
    check("restart_clr", {p1_score, p2_score, round_cnt}, 0);
    play(2'b00, 2'b00, 2'b00);
    check("tie_round", round_cnt, 0);
    check("tie_state", state, 3'b001);
    play(2'b11, 2'b00, 2'b11);
    check("inv_seen", invalid_seen, 1);
    check("inv_round", round_cnt, 0);
    play(2'b00, 2'b01, 2'b10);
    check("p2a_score", p2_score, 1);
    play(2'b01, 2'b10, 2'b10);
    check("p2b_score", p2_score, 2);
    check("p2b_round", round_cnt, 2);
    check("p2b_winner", match_winner, 2'b10);
    check("p2b_inv", invalid_seen, 1);
`ifdef RPS_ROUND_HISTORY_EN
    check("history", round_history, 16'h003A);
`endif

    // Round limit of 2 on the second instance: 1-1 ends as a draw
    start_match();
    play(2'b01, 2'b00, 2'b01);
    play(2'b00, 2'b01, 2'b10);
    check("lim_done", b_match_done, 1);
    check("lim_winner", b_match_winner, 2'b00);
    check("lim_scores", {b_p1_score, b_p2_score}, 8'h11);
    check("nolim_state", state, 3'b001);

    // Evaluator never answers: request lasts exactly 15 cycles
    p1_move = 2'b10; p2_move = 2'b10; moves_valid = 1'b1;
    tick();
    moves_valid = 1'b0;
    check("lim_ignores_moves", b_state, 3'b100);
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!eval_req) break;
      req_cycles++;
      tick();
    end
    check("tmo_cycles", req_cycles, 15);
    check("tmo_done", match_done, 1);
    check("tmo_winner", match_winner, 2'b11);

    // Abort coincident with eval_done discards the result
    start_match();
    play(2'b01, 2'b00, 2'b01);
    p1_move = 2'b01; p2_move = 2'b00; moves_valid = 1'b1;
    tick();
    moves_valid = 1'b0;
    eval_done = 1'b1; eval_winner = 2'b01; abort = 1'b1;
    tick();
    eval_done = 1'b0; abort = 1'b0;
    check("abort_state", state, 0);
    check("abort_req", eval_req, 0);
    check("abort_ready", moves_ready, 0);
    tick();
    check("abort_p1_kept", p1_score, 1);
    check("abort_round_kept", round_cnt, 1);
    start_match();
    check("abort_restart_clr", {p1_score, round_cnt}, 0);

    // Reset in the middle of an evaluation
    p1_move = 2'b10; p2_move = 2'b01; moves_valid = 1'b1;
    tick();
    moves_valid = 1'b0;
    eval_done = 1'b1; eval_winner = 2'b01; reset = 1'b1;
    tick();
    eval_done = 1'b0; reset = 1'b0;
    check("mrst_state", state, 0);
    check("mrst_p1", p1_score, 0);
    check("mrst_evalp", {eval_p1, eval_p2}, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
